arm_cpu: RTL and testbench
==========================

Name: arm_cpu

Overview:
- Compact 3-stage pipelined LEGv8-style CPU core behind the 8-bit tile I/O wrapper.
- Pipeline stages:
  - IF: fetch.
  - EX: decode, register read, ALU, branch, data memory.
  - WB: register write.
- A 16x16 instruction memory is loaded byte-wise through the input pins. Register X7 is continuously driven on uo_out for observation.

Parameters:
None (all sizes fixed).
- Instruction memory: 16 words of 16 bits.
- Registers: 8 of 8 bits.
- Data memory: 8 bytes of 8 bits.

Ports:
- clk    in   1  system clock; all state updates on rising edge.
- rst_n  in   1  reset. Synchronous, active-high (1 = reset). The name is kept for wrapper compatibility.
- ena    in   1  enable; 0 freezes all state.
- ui_in  in   8  program-load data byte.
- uio_in in   8  control:
  - [7] PROG (1 = load mode, pipeline frozen)
  - [5] WE load strobe
  - [4] byte select (1 = high byte)
  - [3:0] imem address
  - [6] unused
- uo_out out  8  current value of register X7.
- uio_out out 8  constant 0.
- uio_oe  out 8  constant 0 (all uio pins are inputs).

Behaviour:
- Reset (rst_n=1 at a rising edge):
  - PC=0; IF/EX and EX/WB registers hold NOP (valid=0).
  - X1..X7=0; data memory=0; uo_out=0.
  - Instruction memory is NOT cleared.
  - Reset has priority over everything else.
- Load mode (ena=1, PROG=1): on an edge with WE=1, imem[uio_in[3:0]] receives ui_in in its high byte (bit4=1) or low byte (bit4=0). The pipeline holds.
- Run (ena=1, PROG=0): the pipeline advances one stage per edge.
- ena=0: nothing changes.
- Instruction format:
  - op=[15:12], rd=[11:9], rn=[8:6], rm=[5:3].
  - imm6=[5:0], zero-extended, except branches.
  - imm8=[7:0].
- Register X0 is XZR: it reads 0 and writes to it are discarded.
- Opcodes (all arithmetic is 8-bit, mod 256):
  - 0 NOP.
  - 1 ADD rd=rn+rm.
  - 2 SUB rd=rn-rm.
  - 3 AND rd=rn&rm.
  - 4 ORR rd=rn|rm.
  - 5 ADDI rd=rn+imm6.
  - 6 SUBI rd=rn-imm6.
  - 7 MOVI rd=imm8.
  - 8 CBZ: if X[rd]==0, PC = bpc + sext(imm6).
  - 9 B: PC = bpc + sext([8:0]). Here bpc is the branch's own address and the 4-bit PC wraps mod 16.
  - 10 LDUR rd = DM[(X[rn]+imm6)[2:0]].
  - 11 STUR DM[(X[rn]+imm6)[2:0]] = X[rd].
  - 12-15 behave as NOP.
- Timing:
  - The instruction fetched at PC is latched into EX on the next run edge.
  - Its result is latched into WB on the following edge and written to the register file on the edge after that.
  - STUR writes data memory at the end of EX.
  - With no branches, instruction k (from reset, run edges counted from 1) updates its destination at edge k+3.
- Forwarding:
  - An EX operand whose register matches the WB-stage destination (valid, writes a register, rd != 0) takes the WB result.
  - Older results are already in the register file.
  - No stalls ever occur; LDUR data is available in EX.
- Branches:
  - Resolved in EX.
  - When taken: PC is loaded with the target, and the instruction in IF is squashed (one bubble, it never writes).
  - Not-taken CBZ costs nothing.
- "B 0" (0x9000) is a self-loop used as halt; X7 then stays stable.
- Mode switch: switching PROG 1→0 resumes from the held pipeline state. Reset is used to restart the program from address 0.

Test Plan:
- Reset → uo_out=0x00, uio_oe=0x00, uio_out=0x00; edges with ena=0 change nothing.
- Load 0x7E2A (MOVI X7,42) at addr 0 and 0x9000 at addr 1, pulse reset, run → uo_out=42 (0x2A) after 3 run edges and stays 42.
- Back-to-back forwarding:
  - Program: MOVI X1,5 (0x7205); ADD X7,X1,X1 (0x1E48); B 0.
  - Required: uo_out=10.
  - Then SUBI X7,X7,11 gives 0xFF (wrap).
- Memory: MOVI X2,0x5A; STUR X2,[X0,#3]; LDUR X7,[X0,#11] (address wraps to 3); halt → uo_out=0x5A.
- Branch squash:
  - Program: MOVI X7,1; B +2; MOVI X7,99; MOVI X7,7; halt.
  - Required: final uo_out=7 and 99 never appears on uo_out.
- CBZ:
  - Taken on X0 (skips an instruction).
  - Not taken with X1=3 (falls through).
  - Write to X0 then ADD X7,X0,X0 → uo_out=0.

Source files
------------

// File: rtl/arm_cpu.sv
// ---------------------------------------------------------------------------
// arm_cpu: compact 3-stage (IF / EX / WB) LEGv8-style core behind an 8-bit
// tile I/O wrapper. The program is written byte-wise into a 16x16
// instruction memory. Register X7 is shown on uo_out for observation.
//
// Ports:
//   clk      rising-edge clock for all state
//   rst_n    synchronous reset, ACTIVE-HIGH despite the name (wrapper legacy)
//   ena      0 freezes every piece of state
//   ui_in    program-load data byte
//   uio_in   [7] PROG load mode, [5] load strobe, [4] high-byte select,
//            [3:0] instruction address, [6] unused
//   uo_out   current value of X7
//   uio_out  constant 0
//   uio_oe   constant 0 (all uio pins are inputs)
// ---------------------------------------------------------------------------
module arm_cpu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // Operand read with XZR and forwarding from the WB stage. The WB result
    // is not yet in the register file while its consumer sits in EX.
    function automatic logic [7:0] read_operand(
        input logic [2:0] idx,
        input logic [7:0] rf_val,
        input logic       wb_we,
        input logic [2:0] wb_rd,
        input logic [7:0] wb_res
    );
        if (idx == 3'd0) begin
            return 8'h00;
        end else if (wb_we && (wb_rd == idx)) begin
            return wb_res;
        end else begin
            return rf_val;
        end
    endfunction

    // Control pin decode
    logic       prog_s;
    logic       load_we_s;
    logic       load_hi_s;
    logic [3:0] load_addr_s;
    logic       run_s;
    logic       unused_s;

    assign prog_s      = uio_in[7];
    assign load_we_s   = uio_in[5];
    assign load_hi_s   = uio_in[4];
    assign load_addr_s = uio_in[3:0];
    assign run_s       = ena && !prog_s;
    assign unused_s    = uio_in[6];

    // Architectural and pipeline state
    logic [15:0] imem_q [0:15];
    logic [7:0]  rf_q   [0:7];
    logic [7:0]  dmem_q [0:7];

    logic [3:0]  pc_q,         pc_d;
    logic        ifex_valid_q, ifex_valid_d;
    logic [15:0] ifex_instr_q, ifex_instr_d;
    logic [3:0]  ifex_pc_q,    ifex_pc_d;
    logic        exwb_we_q,    exwb_we_d;
    logic [2:0]  exwb_rd_q,    exwb_rd_d;
    logic [7:0]  exwb_res_q,   exwb_res_d;

    // EX-stage decode
    logic [3:0] op_s;
    logic [2:0] rd_s;
    logic [2:0] rn_s;
    logic [2:0] rm_s;
    logic [5:0] imm6_s;
    logic [7:0] imm8_s;
    logic [7:0] rd_val_s;
    logic [7:0] rn_val_s;
    logic [7:0] rm_val_s;
    logic [2:0] ea_s;
    logic [7:0] res_s;
    logic       wr_s;
    logic       taken_s;
    logic [3:0] target_s;
    logic       dm_we_s;

    assign op_s   = ifex_instr_q[15:12];
    assign rd_s   = ifex_instr_q[11:9];
    assign rn_s   = ifex_instr_q[8:6];
    assign rm_s   = ifex_instr_q[5:3];
    assign imm6_s = ifex_instr_q[5:0];
    assign imm8_s = ifex_instr_q[7:0];

    assign rd_val_s = read_operand(rd_s, rf_q[rd_s], exwb_we_q, exwb_rd_q, exwb_res_q);
    assign rn_val_s = read_operand(rn_s, rf_q[rn_s], exwb_we_q, exwb_rd_q, exwb_res_q);
    assign rm_val_s = read_operand(rm_s, rf_q[rm_s], exwb_we_q, exwb_rd_q, exwb_res_q);

    // Only the low 3 bits of X[rn]+imm6 address the 8-byte data memory.
    assign ea_s = rn_val_s[2:0] + imm6_s[2:0];

    // ALU, memory read and branch resolution for the instruction in EX.
    // Branch offsets only matter mod 16, so the low 4 bits of the
    // sign-extended offset are the offset bits themselves.
    always_comb begin
        res_s    = 8'h00;
        wr_s     = 1'b0;
        taken_s  = 1'b0;
        target_s = ifex_pc_q;
        dm_we_s  = 1'b0;
        if (ifex_valid_q) begin
            case (op_s)
                4'd1:    begin res_s = rn_val_s + rm_val_s;          wr_s = 1'b1; end
                4'd2:    begin res_s = rn_val_s - rm_val_s;          wr_s = 1'b1; end
                4'd3:    begin res_s = rn_val_s & rm_val_s;          wr_s = 1'b1; end
                4'd4:    begin res_s = rn_val_s | rm_val_s;          wr_s = 1'b1; end
                4'd5:    begin res_s = rn_val_s + {2'b00, imm6_s};   wr_s = 1'b1; end
                4'd6:    begin res_s = rn_val_s - {2'b00, imm6_s};   wr_s = 1'b1; end
                4'd7:    begin res_s = imm8_s;                       wr_s = 1'b1; end
                4'd8:    begin
                    taken_s  = (rd_val_s == 8'h00);
                    target_s = ifex_pc_q + imm6_s[3:0];
                end
                4'd9:    begin
                    taken_s  = 1'b1;
                    target_s = ifex_pc_q + ifex_instr_q[3:0];
                end
                4'd10:   begin res_s = dmem_q[ea_s];                 wr_s = 1'b1; end
                4'd11:   begin dm_we_s = 1'b1; end
                default: begin res_s = 8'h00;                        wr_s = 1'b0; end
            endcase
        end else begin
            res_s = 8'h00;
            wr_s  = 1'b0;
        end
    end

    // Next-state values for PC and the two pipeline registers; a taken
    // branch squashes the instruction being fetched in the same cycle.
    always_comb begin
        pc_d         = taken_s ? target_s : (pc_q + 4'd1);
        ifex_valid_d = !taken_s;
        ifex_instr_d = imem_q[pc_q];
        ifex_pc_d    = pc_q;
        exwb_we_d    = wr_s && (rd_s != 3'd0);
        exwb_rd_d    = rd_s;
        exwb_res_d   = res_s;
    end

    // Pipeline, register file and data memory update.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc_q         <= 4'd0;
            ifex_valid_q <= 1'b0;
            ifex_instr_q <= 16'h0000;
            ifex_pc_q    <= 4'd0;
            exwb_we_q    <= 1'b0;
            exwb_rd_q    <= 3'd0;
            exwb_res_q   <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                rf_q[i]   <= 8'h00;
                dmem_q[i] <= 8'h00;
            end
        end else if (run_s) begin
            pc_q         <= pc_d;
            ifex_valid_q <= ifex_valid_d;
            ifex_instr_q <= ifex_instr_d;
            ifex_pc_q    <= ifex_pc_d;
            exwb_we_q    <= exwb_we_d;
            exwb_rd_q    <= exwb_rd_d;
            exwb_res_q   <= exwb_res_d;
            if (exwb_we_q) begin
                rf_q[exwb_rd_q] <= exwb_res_q;
            end
            if (dm_we_s) begin
                dmem_q[ea_s] <= rd_val_s;
            end
        end
    end

    // Byte-wise program load; instruction memory survives reset.
    always_ff @(posedge clk) begin
        if (!rst_n && ena && prog_s && load_we_s) begin
            if (load_hi_s) begin
                imem_q[load_addr_s][15:8] <= ui_in;
            end else begin
                imem_q[load_addr_s][7:0] <= ui_in;
            end
        end
    end

    assign uo_out  = rf_q[7];
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_arm_cpu.sv
// ---------------------------------------------------------------------------
// tb_arm_cpu: directed programs for arm_cpu. Each program pushes the ordered
// sequence of X7 values it must produce into a scoreboard queue; a monitor
// pops and compares whenever uo_out changes, so any extra value (such as a
// squashed write) is reported. Directed checks pin down exact latencies.
// ---------------------------------------------------------------------------
module tb_arm_cpu;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    arm_cpu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  last_seen = 8'h00;
    logic        mon_en = 1'b0;
    logic [15:0] prog_r [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Scoreboard monitor: every change of X7 must match the next queued value.
    always @(negedge clk) begin
        if (mon_en && (uo_out !== last_seen)) begin
            if (exp_q.size() == 0) begin
                check("x7_unexpected_change", {24'h0, uo_out}, {24'h0, last_seen});
            end else begin
                check("x7_sequence", {24'h0, uo_out}, {24'h0, exp_q.pop_front()});
            end
            last_seen = uo_out;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic load_word(input logic [3:0] a, input logic [15:0] w);
        uio_in = {1'b1, 1'b0, 1'b1, 1'b1, a};
        ui_in  = w[15:8];
        tick(1);
        uio_in = {1'b1, 1'b0, 1'b1, 1'b0, a};
        ui_in  = w[7:0];
        tick(1);
        uio_in = {1'b1, 1'b0, 1'b0, 1'b0, a};
        ui_in  = 8'h00;
    endtask

    task automatic clear_prog();
        for (int a = 0; a < 16; a++) prog_r[a] = 16'h0000;
    endtask

    // Load the whole image, reset, then start running with the monitor armed.
    task automatic start_prog(input string name);
        mon_en = 1'b0;
        for (int a = 0; a < 16; a++) load_word(a[3:0], prog_r[a]);
        rst_n = 1'b1;
        tick(1);
        rst_n = 1'b0;
        check({name, "_reset_x7"}, {24'h0, uo_out}, 32'h0);
        last_seen = 8'h00;
        exp_q.delete();
        uio_in = 8'h00;
        mon_en = 1'b1;
    endtask

    task automatic end_prog(input string name, input logic [7:0] final_x7);
        check({name, "_final_x7"}, {24'h0, uo_out}, {24'h0, final_x7});
        check({name, "_queue_drained"}, exp_q.size(), 32'h0);
        mon_en = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        @(negedge clk);
        tick(2);
        rst_n = 1'b0;
        check("reset_uo_out",  {24'h0, uo_out},  32'h0);
        check("reset_uio_oe",  {24'h0, uio_oe},  32'h0);
        check("reset_uio_out", {24'h0, uio_out}, 32'h0);
        ena = 1'b0;
        tick(4);
        check("ena0_idle_uo_out", {24'h0, uo_out}, 32'h0);
        ena = 1'b1;

        // MOVI X7,42 ; halt
        clear_prog();
        prog_r[0] = 16'h7E2A;
        prog_r[1] = 16'h9000;
        start_prog("movi");
        exp_q.push_back(8'h2A);
        tick(2);
        check("movi_after2", {24'h0, uo_out}, 32'h00);
        tick(1);
        check("movi_after3", {24'h0, uo_out}, 32'h2A);
        tick(10);
        end_prog("movi", 8'h2A);

        // MOVI X1,5 ; ADD X7,X1,X1 ; SUBI X7,X7,11 ; halt  (with freezes)
        clear_prog();
        prog_r[0] = 16'h7205;
        prog_r[1] = 16'h1E48;
        prog_r[2] = 16'h6FCB;
        prog_r[3] = 16'h9000;
        start_prog("fwd");
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'hFF);
        tick(3);
        check("fwd_after3", {24'h0, uo_out}, 32'h00);
        ena = 1'b0;
        tick(5);
        check("fwd_ena0_freeze", {24'h0, uo_out}, 32'h00);
        ena = 1'b1;
        tick(1);
        check("fwd_add", {24'h0, uo_out}, 32'h0A);
        uio_in = 8'h80;
        tick(4);
        check("fwd_prog_hold", {24'h0, uo_out}, 32'h0A);
        uio_in = 8'h00;
        tick(1);
        check("fwd_subi_wrap", {24'h0, uo_out}, 32'hFF);
        tick(8);
        end_prog("fwd", 8'hFF);

        // MOVI X2,0x5A ; STUR X2,[X0,#3] ; LDUR X7,[X0,#11] ; halt
        clear_prog();
        prog_r[0] = 16'h745A;
        prog_r[1] = 16'hB403;
        prog_r[2] = 16'hAE0B;
        prog_r[3] = 16'h9000;
        start_prog("mem");
        exp_q.push_back(8'h5A);
        tick(4);
        check("mem_after4", {24'h0, uo_out}, 32'h00);
        tick(1);
        check("mem_ldur", {24'h0, uo_out}, 32'h5A);
        tick(8);
        end_prog("mem", 8'h5A);

        // MOVI X7,1 ; B +2 ; MOVI X7,99 ; MOVI X7,7 ; halt
        clear_prog();
        prog_r[0] = 16'h7E01;
        prog_r[1] = 16'h9002;
        prog_r[2] = 16'h7E63;
        prog_r[3] = 16'h7E07;
        prog_r[4] = 16'h9000;
        start_prog("squash");
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h07);
        tick(5);
        check("squash_after5", {24'h0, uo_out}, 32'h01);
        tick(1);
        check("squash_after6", {24'h0, uo_out}, 32'h07);
        tick(10);
        end_prog("squash", 8'h07);

        // CBZ X0,+2 ; MOVI X7,99 ; MOVI X1,3 ; CBZ X1,+2 ; MOVI X7,0x11 ;
        // MOVI X0,0x33 ; ADD X7,X0,X0 ; halt
        clear_prog();
        prog_r[0] = 16'h8002;
        prog_r[1] = 16'h7E63;
        prog_r[2] = 16'h7203;
        prog_r[3] = 16'h8202;
        prog_r[4] = 16'h7E11;
        prog_r[5] = 16'h7033;
        prog_r[6] = 16'h1E00;
        prog_r[7] = 16'h9000;
        start_prog("cbz");
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h00);
        tick(6);
        check("cbz_after6", {24'h0, uo_out}, 32'h00);
        tick(1);
        check("cbz_fallthrough", {24'h0, uo_out}, 32'h11);
        tick(2);
        check("cbz_xzr_add", {24'h0, uo_out}, 32'h00);
        tick(8);
        end_prog("cbz", 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

endmodule
